// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and helpers for the serial adder/subtractor.
//   state_t : controller state encoding (IDLE, RUN, DONE)
//   clog2   : ceiling log2, used to size the step counter
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_addsub_fa_slice.sv
// fa_slice: combinational ripple of SLICE one-bit full adders.
//   a, b  : SLICE-bit operand digits
//   ci    : carry into bit 0
//   s     : SLICE-bit sum digit
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (for signed overflow detection)
module fa_slice #(
  parameter int SLICE = 1
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [SLICE:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < SLICE; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co    = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor reusing one SLICE-bit adder
// slice for WIDTH/SLICE cycles, carry held in a register between cycles.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : request, accepted while busy==0
//   sub        : 0 -> a+b+c_in, 1 -> a-b-c_in (c_in is borrow-in)
//   a, b, c_in : operands, captured at the accepted start
//   busy       : computation in progress
//   done       : one-cycle pulse when s/c_out/ovf update
//   s          : WIDTH-bit result, held between completions
//   c_out      : carry out of MSB (sub mode: 1 = no borrow)
//   ovf        : two's-complement overflow
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  generate
    if (WIDTH < 2 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and SLICE must divide WIDTH");
    end
  endgenerate

  localparam int unsigned STEPS = WIDTH / SLICE;
  localparam int unsigned SW    = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
  localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_next;
  logic             carry;
  logic [SW-1:0]    step;

  logic [SLICE-1:0] sl_s;
  logic             sl_co;
  logic             sl_cmsb;

  // Operands shift down one digit per step so the slice always reads the
  // low digit; the sum digit enters the shadow register from the top.
  fa_slice #(.SLICE(SLICE)) u_slice (
    .a     (op_a[SLICE-1:0]),
    .b     (op_b[SLICE-1:0]),
    .ci    (carry),
    .s     (sl_s),
    .co    (sl_co),
    .c_msb (sl_cmsb)
  );

  always_comb begin
    shadow_next                   = shadow >> SLICE;
    shadow_next[WIDTH-1 -: SLICE] = sl_s;
  end

  assign busy = (state == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      shadow <= '0;
      carry  <= 1'b0;
      step   <= '0;
      done   <= 1'b0;
      s      <= '0;
      c_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == RUN) begin
        op_a   <= op_a >> SLICE;
        op_b   <= op_b >> SLICE;
        shadow <= shadow_next;
        carry  <= sl_co;
        step   <= step + 1'b1;
        if (step == LAST) begin
          s     <= shadow_next;
          c_out <= sl_co;
          ovf   <= sl_cmsb ^ sl_co;
          done  <= 1'b1;
          state <= DONE;
        end
      end else if (start) begin
        // Subtraction is a + ~b + ~borrow_in.
        op_a   <= a;
        op_b   <= b ^ {WIDTH{sub}};
        carry  <= c_in ^ sub;
        step   <= '0;
        shadow <= '0;
        state  <= RUN;
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic        clk;
  logic        rst;

  logic        start1, sub1, cin1;
  logic [7:0]  a1, b1;
  logic        busy1, done1, c1, o1;
  logic [7:0]  s1;

  logic        start2, sub2, cin2;
  logic [15:0] a2, b2;
  logic        busy2, done2, c2, o2;
  logic [15:0] s2;

  int checks;
  int failures;

  serial_addsub #(.WIDTH(8), .SLICE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .s(s1), .c_out(c1), .ovf(o1)
  );

  serial_addsub #(.WIDTH(16), .SLICE(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2), .c_in(cin2),
    .busy(busy2), .done(done2), .s(s2), .c_out(c2), .ovf(o2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait1(output int n, output int bc);
    n = 0;
    bc = 0;
    while (n < 30) begin
      tick();
      n++;
      if (busy1) bc++;
      if (done1) break;
    end
  endtask

  task automatic wait2(output int n);
    n = 0;
    while (n < 30) begin
      tick();
      n++;
      if (done2) break;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                     input logic tc, input logic ts, input logic [7:0] es,
                     input logic ec, input logic eo, input logic [7:0] prev);
    int n, bc;
    a1 = ta; b1 = tb_; cin1 = tc; sub1 = ts; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1 = ~ta; b1 = 8'h00; cin1 = ~tc; sub1 = ~ts;
    chk({tag, "_busy_on"}, 32'(busy1), 32'd1);
    chk({tag, "_s_held"}, 32'(s1), 32'(prev));
    wait1(n, bc);
    chk({tag, "_latency"}, n, 32'd8);
    chk({tag, "_busy_cycles"}, bc + 1, 32'd8);
    chk({tag, "_s"}, 32'(s1), 32'(es));
    chk({tag, "_c_out"}, 32'(c1), 32'(ec));
    chk({tag, "_ovf"}, 32'(o1), 32'(eo));
    tick();
    chk({tag, "_done_width"}, 32'(done1), 32'd0);
  endtask

  task automatic op16(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                      input logic tc, input logic ts, input logic [15:0] es,
                      input logic ec, input logic eo);
    int n;
    a2 = ta; b2 = tb_; cin2 = tc; sub2 = ts; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    a2 = 16'h0; b2 = ~tb_;
    wait2(n);
    chk({tag, "_latency"}, n, 32'd4);
    chk({tag, "_s"}, 32'(s2), 32'(es));
    chk({tag, "_c_out"}, 32'(c2), 32'(ec));
    chk({tag, "_ovf"}, 32'(o2), 32'(eo));
    tick();
  endtask

  initial begin
    int n, bc;
    logic [15:0] ra, rb, es;
    logic        rc, rs, ec, eo;
    logic [16:0] full;
    int          sr;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    start1 = 0; sub1 = 0; cin1 = 0; a1 = '0; b1 = '0;
    start2 = 0; sub2 = 0; cin2 = 0; a2 = '0; b2 = '0;
    repeat (2) tick();
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_s", 32'(s1), 32'd0);
    chk("rst_c_out", 32'(c1), 32'd0);
    chk("rst_ovf", 32'(o1), 32'd0);
    rst = 1'b0;
    tick();

    // Directed adds and subtracts, 8-bit, one bit per cycle.
    op8("t1_add", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 8'h00);
    op8("t2_add_cin", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 8'h96);
    op8("t3_sub_borrow", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 8'h01);
    op8("t3_sub_ovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'hF0);
    op8("t3_sub_bin", 8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0, 8'h7F);

    // Start while busy is ignored.
    a1 = 8'h5A; b1 = 8'h3C; cin1 = 0; sub1 = 0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (3) tick();
    a1 = 8'h01; b1 = 8'h01; sub1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t4_busy_kept", 32'(busy1), 32'd1);
    wait1(n, bc);
    chk("t4_latency", n + 4, 32'd8);
    chk("t4_s", 32'(s1), 32'h96);
    chk("t4_c_out", 32'(c1), 32'd0);
    chk("t4_ovf", 32'(o1), 32'd1);
    tick();
    chk("t4_not_queued", 32'(busy1), 32'd0);

    // Start held high: next accept happens in the DONE cycle.
    a1 = 8'h11; b1 = 8'h22; cin1 = 0; sub1 = 0; start1 = 1'b1;
    tick();
    a1 = 8'h40; b1 = 8'h02;
    wait1(n, bc);
    chk("t4_b2b_lat1", n, 32'd8);
    chk("t4_b2b_s1", 32'(s1), 32'h33);
    tick();
    start1 = 1'b0;
    chk("t4_b2b_busy", 32'(busy1), 32'd1);
    wait1(n, bc);
    chk("t4_b2b_gap", n + 1, 32'd9);
    chk("t4_b2b_s2", 32'(s1), 32'h42);
    tick();

    // Async reset mid-operation.
    op8("t5_pre", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 8'h42);
    a1 = 8'h33; b1 = 8'h44; cin1 = 0; sub1 = 0; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", 32'(busy1), 32'd0);
    chk("t5_rst_done", 32'(done1), 32'd0);
    chk("t5_rst_s", 32'(s1), 32'd0);
    chk("t5_rst_c_out", 32'(c1), 32'd0);
    chk("t5_rst_ovf", 32'(o1), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    op8("t5_post", 8'h33, 8'h44, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00);

    // 16-bit, four bits per cycle.
    op16("t6_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op16("t6_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    op16("t6_sub", 16'h1234, 16'h0235, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (rs) begin
        full = {1'b0, ra} - {1'b0, rb} - 17'(rc);
        ec   = ~full[16];
        sr   = int'($signed(ra)) - int'($signed(rb)) - int'(rc);
      end else begin
        full = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        ec   = full[16];
        sr   = int'($signed(ra)) + int'($signed(rb)) + int'(rc);
      end
      es = full[15:0];
      eo = (sr > 32767) || (sr < -32768);
      op16("t6_rand", ra, rb, rc, rs, es, ec, eo);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
